// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word shift register: the first byte shifted in ends up in bits [7:0].
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] shift_reg;
    logic [1:0]  cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (shift_en) begin
            shift_reg <= {byte_in, shift_reg[31:8]};
            cnt_reg   <= cnt_reg + 2'd1;
        end
    end

    // Asserted on the shift that completes a word; the counter wraps to 0 on that edge.
    assign word_full = shift_en && !clear && (cnt_reg == 2'(BYTES_PER_WORD - 1));
    assign word      = shift_reg;

endmodule

// File: rtl/imem_loader.sv
// Parses a count-prefixed little-endian byte stream and writes the words into instruction memory,
// holding the CPU in reset until the load finishes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                      ADDRESS_WIDTH = 32,
    parameter int                      DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                      MAX_WORDS     = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    state_t state_reg, state_next;
    logic [15:0] count_reg, count_next;
    logic [15:0] index_reg, index_next;
    logic [15:0] hdr_count;
    logic [ADDRESS_WIDTH-1:0] waddr_reg, waddr_live;
    logic [DATA_WIDTH-1:0]    wdata_reg, wdata_live;
    logic        xfer;
    logic        asm_clear;
    logic        asm_shift;
    logic        asm_full;
    logic [31:0] asm_word;

    word_assembler u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (byte_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    assign byte_ready = (state_reg == HDR0) || (state_reg == HDR1) || (state_reg == DATA);
    assign busy       = byte_ready || (state_reg == WRITE);
    assign done       = (state_reg == DONE);
    assign err        = (state_reg == ERR);
    assign cpu_rst    = (state_reg != DONE);
    assign we         = (state_reg == WRITE);
    assign xfer       = byte_valid && byte_ready;

    assign waddr_live = BASE_ADDR + ADDRESS_WIDTH'({index_reg, 2'b00});
    assign wdata_live = DATA_WIDTH'(asm_word);

    // Live values during WRITE, captured copies afterwards so the bus holds the last write.
    assign waddr = (state_reg == WRITE) ? waddr_live : waddr_reg;
    assign wdata = (state_reg == WRITE) ? wdata_live : wdata_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        index_next = index_reg;
        hdr_count  = {byte_data, count_reg[7:0]};
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = HDR0;
            end
            HDR0: begin
                if (xfer) begin
                    count_next = {8'h00, byte_data};
                    state_next = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    count_next = hdr_count;
                    if (hdr_count == 16'd0) begin
                        state_next = DONE;
                    end else if (hdr_count > MAX_COUNT) begin
                        state_next = ERR;
                    end else begin
                        index_next = '0;
                        asm_clear  = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                asm_shift = xfer;
                if (asm_full) state_next = WRITE;
            end
            WRITE: begin
                if (index_reg == count_reg - 16'd1) begin
                    state_next = DONE;
                end else begin
                    index_next = index_reg + 16'd1;
                    state_next = DATA;
                end
            end
            DONE, ERR: begin
                if (start) state_next = HDR0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            index_reg <= '0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            index_reg <= index_next;
            if (state_reg == WRITE) begin
                waddr_reg <= waddr_live;
                wdata_reg <= wdata_live;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader (MAX_WORDS=4, BASE_ADDR=0).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [31:0] cap_addr [$];
    logic [31:0] cap_data [$];

    typedef struct {
        string       name;
        int          n;
        logic [143:0] bytes;
        bit          gap;
        int          nw;
        logic [31:0] exp_data [4];
        bit          exp_err;
    } vec_t;

    vec_t vecs [7];

    imem_loader #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (32'h0),
        .MAX_WORDS     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Record every write and confirm the loader never accepts bytes while writing.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            cap_addr.push_back(waddr);
            cap_data.push_back(wdata);
            check("ready_low_in_write", 64'(byte_ready), 64'd0);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                got = 1'b1;
            end
        end
        if (!got) check("byte_accept_timeout", 64'd0, 64'd1);
        byte_valid = 1'b0;
    endtask

    task automatic run_vec(input int v);
        logic [7:0] b;
        cap_addr.delete();
        cap_data.delete();
        do_start();
        check({vecs[v].name, "_hdr0_entry"},
              64'({busy, byte_ready, done, err, cpu_rst}), 64'(5'b11001));
        for (int k = 0; k < vecs[v].n; k++) begin
            if (vecs[v].gap) begin
                byte_valid = 1'b0;
                @(posedge clk); #1;
            end
            b = vecs[v].bytes[8*(vecs[v].n-1-k) +: 8];
            send_byte(b);
        end
        if (vecs[v].nw > 0) begin
            @(negedge clk);
            check({vecs[v].name, "_last_write_cycle"}, 64'({we, done, busy}), 64'(3'b101));
        end
        @(negedge clk);
        check({vecs[v].name, "_final_flags"}, 64'({done, err, cpu_rst, busy}),
              vecs[v].exp_err ? 64'(4'b0110) : 64'(4'b1000));
        check({vecs[v].name, "_write_count"}, 64'(cap_addr.size()), 64'(vecs[v].nw));
        for (int i = 0; i < vecs[v].nw && i < cap_addr.size(); i++) begin
            check({vecs[v].name, "_waddr"}, 64'(cap_addr[i]), 64'(i * 4));
            check({vecs[v].name, "_wdata"}, 64'(cap_data[i]), 64'(vecs[v].exp_data[i]));
        end
        if (vecs[v].nw > 0)
            check({vecs[v].name, "_waddr_hold"}, 64'(waddr), 64'((vecs[v].nw - 1) * 4));
    endtask

    initial begin
        int bad;

        vecs[0].name = "two_word"; vecs[0].n = 10; vecs[0].gap = 1'b0; vecs[0].nw = 2; vecs[0].exp_err = 1'b0;
        vecs[0].bytes = 144'({8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
        vecs[0].exp_data[0] = 32'h00500013; vecs[0].exp_data[1] = 32'h00100093;
        vecs[0].exp_data[2] = '0;           vecs[0].exp_data[3] = '0;

        vecs[1].name = "zero_count"; vecs[1].n = 2; vecs[1].gap = 1'b0; vecs[1].nw = 0; vecs[1].exp_err = 1'b0;
        vecs[1].bytes = 144'({8'h00, 8'h00});
        for (int i = 0; i < 4; i++) vecs[1].exp_data[i] = '0;

        vecs[2].name = "overflow_5"; vecs[2].n = 2; vecs[2].gap = 1'b0; vecs[2].nw = 0; vecs[2].exp_err = 1'b1;
        vecs[2].bytes = 144'({8'h05, 8'h00});
        for (int i = 0; i < 4; i++) vecs[2].exp_data[i] = '0;

        vecs[3].name = "one_word"; vecs[3].n = 6; vecs[3].gap = 1'b0; vecs[3].nw = 1; vecs[3].exp_err = 1'b0;
        vecs[3].bytes = 144'({8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
        vecs[3].exp_data[0] = 32'h12345678;
        for (int i = 1; i < 4; i++) vecs[3].exp_data[i] = '0;

        vecs[4].name = "overflow_256"; vecs[4].n = 2; vecs[4].gap = 1'b0; vecs[4].nw = 0; vecs[4].exp_err = 1'b1;
        vecs[4].bytes = 144'({8'h00, 8'h01});
        for (int i = 0; i < 4; i++) vecs[4].exp_data[i] = '0;

        vecs[5].name = "max_words_gap"; vecs[5].n = 18; vecs[5].gap = 1'b1; vecs[5].nw = 4; vecs[5].exp_err = 1'b0;
        vecs[5].bytes = {8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                         8'h01, 8'h02, 8'h03, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        vecs[5].exp_data[0] = 32'h44332211; vecs[5].exp_data[1] = 32'h88776655;
        vecs[5].exp_data[2] = 32'h04030201; vecs[5].exp_data[3] = 32'hDEADBEEF;

        vecs[6] = vecs[0];
        vecs[6].name = "two_word_gap";
        vecs[6].gap  = 1'b1;

        // Reset state, asserted asynchronously from time zero.
        #1;
        check("reset_flags", 64'({cpu_rst, byte_ready, we, busy, done, err}), 64'(6'b100000));
        check("reset_waddr", 64'(waddr), 64'd0);
        check("reset_wdata", 64'(wdata), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle ignores a valid byte source.
        byte_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (byte_ready !== 1'b0 || we !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_ignores_bytes", 64'(bad), 64'd0);
        byte_valid = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) run_vec(v);

        // Reset inside a partial word discards it.
        cap_addr.delete();
        cap_data.delete();
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #2;
        check("midword_rst_flags", 64'({busy, byte_ready, cpu_rst, we, done}), 64'(5'b00100));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midword_no_write", 64'(cap_addr.size()), 64'd0);
        check("midword_idle", 64'({busy, done, err}), 64'd0);
        @(posedge clk); #1;
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
